regfile_arbiter2: RTL
=====================

Name: regfile_arbiter2

Overview:
- Two-requester arbiter and sequencer in front of the 4x16 register file.
- Shares the file's single write/read address port between requesters A and B using round-robin.
- Supports three operations per request: READ, WRITE, and atomic ADD (read-modify-write, returns the old value).
- Drives the file's we/addr/wdata and samples its combinational rdata; never exposes the file directly to requesters.

Parameters:
DW, 16, data width (matches register file width)
AW, 2, address width (4 registers)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
a_req  input  1  requester A request; held with op/addr/data stable until a_ack
a_op  input  2  A operation: 0 READ, 1 WRITE, 2 ADD, 3 NOP
a_addr  input  AW  A register address
a_data  input  DW  A write data / addend
a_ack  output  1  one-cycle completion pulse to A
a_rdata  output  DW  A result (registered; holds until A's next completion)
b_req, b_op, b_addr, b_data  input  1/2/AW/DW  same as A, for requester B
b_ack  output  1  one-cycle completion pulse to B
b_rdata  output  DW  B result
rf_we  output  1  register-file write enable
rf_addr  output  AW  register-file address
rf_wdata  output  DW  register-file write data
rf_rdata  input  DW  register-file combinational read data for rf_addr
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n: when rst_n=0 at a rising edge, all state is reset.
- Reset values:
  - state=IDLE, prio=A.
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - rf_we=0, rf_addr=0, rf_wdata=0, busy=0.
- State machine: IDLE, EXEC, WB, RESP.
- IDLE:
  - If any req is high, select a winner: prio side if it requests, else the other side.
  - Latch owner, op, addr, data; go to EXEC.
  - No request: stay in IDLE.
- EXEC: rf_addr=latched addr.
  - READ: capture rf_rdata into the owner's rdata; go to RESP.
  - WRITE: rf_we=1, rf_wdata=data; go to RESP; owner rdata unchanged.
  - ADD: capture rf_rdata into internal old; go to WB.
  - NOP: owner rdata<=0; no write; go to RESP.
- WB (ADD only):
  - rf_addr=latched addr, rf_we=1, rf_wdata=(old+data) mod 2^DW, carry discarded.
  - Owner rdata<=old; go to RESP.
- RESP:
  - Owner's ack=1 for exactly this cycle; the other ack stays 0.
  - prio<=non-owner; go to IDLE.
- Acks are decoded from registered state/owner only, never combinationally from req.
- Latency from the first IDLE cycle with req high to ack:
  - READ, WRITE, NOP: ack in the 3rd cycle (IDLE, EXEC, RESP).
  - ADD: ack in the 4th cycle.
  - Back-to-back: next grant is sampled in the IDLE cycle after RESP. Minimum spacing between acks is 3 cycles for READ/WRITE/NOP, 4 for ADD.
- Outside EXEC/WB: rf_we=0, rf_addr=0, rf_wdata=0.
- rf_we is high in at most one cycle per request.
- Requester rules: a req that drops before its ack is a protocol violation. The latched copy is used regardless, so the operation still completes.
- Starvation: with both requesting continuously, grants strictly alternate A, B, A, B, ...
- Simultaneous requests after reset: A wins first.
- Reset mid-operation (any state):
  - Next state is IDLE; the pending op is discarded with no ack.
  - rf_we=0 from that cycle on. A WB aborted by reset performs no write.
  - rdata outputs and prio are reset.
- rf_rdata is sampled only in EXEC; its value in other cycles is ignored.

Test Plan:
1. Reset, then A WRITE addr2 data 0x1234; later A READ addr2 -> rf_we high exactly 1 cycle with rf_addr=2, rf_wdata=0x1234; READ a_ack in the 3rd cycle, a_rdata=0x1234; b_ack never high.
2. Reg1=0xFFF0; B ADD addr1 data 0x0015 -> b_ack in the 4th cycle, b_rdata=0xFFF0; reg1=0x0005 (wrap); rf_we high only in the WB cycle.
3. A and B both hold READ requests from the cycle after reset -> acks in order A, B, A, B; each ack 3 cycles after the previous; no ack ever overlaps.
4. A ADD addr0 +1 and B ADD addr0 +1 simultaneously, reg0=7 -> A gets rdata 7, B gets rdata 8, reg0=9 (atomicity).
5. A ADD issued; rst_n=0 during the WB cycle -> no rf_we that cycle, no a_ack; reg0 unchanged; all outputs 0 the next cycle; busy=0.
6. A NOP addr3 after a_rdata=0xBEEF -> no rf_we, a_ack in the 3rd cycle, a_rdata=0x0000.

Source files
------------

// File: rtl/regfile_arbiter2.sv
// Round-robin arbiter and sequencer sharing one 4x16 register-file port between two requesters.
// Supports READ, WRITE, atomic ADD (returns old value) and NOP per request.
module regfile_arbiter2 #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic [1:0]    a_op,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic [1:0]    b_op,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic          busy
);

    localparam logic [1:0] OpRead  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpAdd   = 2'd2;

    typedef enum logic [1:0] {StIdle, StExec, StWb, StResp} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;  // 0 = A, 1 = B
    logic          prio_q, prio_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] old_q, old_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          grant_b;
    logic          result_en;
    logic [DW-1:0] result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            op_q      <= 2'd0;
            addr_q    <= '0;
            data_q    <= '0;
            old_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            old_q     <= old_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        // Priority side wins if it requests, otherwise the other side.
        grant_b   = prio_q ? (b_req | ~a_req) : (~a_req & b_req);
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        old_d     = old_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        result_en = 1'b0;
        result    = '0;
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    owner_d = grant_b;
                    op_d    = grant_b ? b_op : a_op;
                    addr_d  = grant_b ? b_addr : a_addr;
                    data_d  = grant_b ? b_data : a_data;
                    state_d = StExec;
                end
            end
            StExec: begin
                unique case (op_q)
                    OpRead: begin
                        result_en = 1'b1;
                        result    = rf_rdata;
                        state_d   = StResp;
                    end
                    OpWrite: state_d = StResp;
                    OpAdd: begin
                        old_d   = rf_rdata;
                        state_d = StWb;
                    end
                    default: begin
                        result_en = 1'b1;
                        result    = '0;
                        state_d   = StResp;
                    end
                endcase
            end
            StWb: begin
                result_en = 1'b1;
                result    = old_q;
                state_d   = StResp;
            end
            StResp: begin
                prio_d  = ~owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (result_en) begin
            if (owner_q) begin
                b_rdata_d = result;
            end else begin
                a_rdata_d = result;
            end
        end
    end

    // Register-file strobes are gated by rst_n so a reset in EXEC/WB suppresses the write.
    always_comb begin
        rf_we    = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        if (rst_n && state_q == StExec) begin
            rf_addr = addr_q;
            if (op_q == OpWrite) begin
                rf_we    = 1'b1;
                rf_wdata = data_q;
            end
        end else if (rst_n && state_q == StWb) begin
            rf_addr  = addr_q;
            rf_we    = 1'b1;
            rf_wdata = old_q + data_q;
        end
        a_ack   = rst_n && (state_q == StResp) && !owner_q;
        b_ack   = rst_n && (state_q == StResp) && owner_q;
        a_rdata = a_rdata_q;
        b_rdata = b_rdata_q;
        busy    = (state_q != StIdle);
    end

endmodule
